// File: rtl/sram_arbiter.sv
`default_nettype none
// sram_arbiter: two-requester SRAM-like bus arbiter with an in-order response routing FIFO.
// Build option ARB_RR_EN: round-robin arbitration instead of fixed priority with starvation guard.
module sram_arbiter #(
  parameter int OT_DEPTH   = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      m0_req,
  input  logic                      m0_wr,
  input  logic [1:0]                m0_size,
  input  logic [3:0]                m0_wstrb,
  input  logic [31:0]               m0_addr,
  input  logic [31:0]               m0_wdata,
  output logic                      m0_addr_ok,
  output logic                      m0_data_ok,
  output logic [31:0]               m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_wr,
  input  logic [1:0]                m1_size,
  input  logic [3:0]                m1_wstrb,
  input  logic [31:0]               m1_addr,
  input  logic [31:0]               m1_wdata,
  output logic                      m1_addr_ok,
  output logic                      m1_data_ok,
  output logic [31:0]               m1_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [3:0]                s_wstrb,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [31:0]               s_rdata,
  output logic [$clog2(OT_DEPTH):0] ot_cnt,
  output logic                      arb_err
);

  localparam int PW = $clog2(OT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(OT_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          fifo_q [OT_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic pick;
  logic sel;
  logic sreq;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic head;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  // Contention goes to whichever requester did not win the previous arbitration.
  always_comb begin
    pick = m1_req;
    if (m0_req && m1_req) pick = ~last_q;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && sreq) last_d = pick;
  end

  always_ff @(posedge aclk) begin
    if (areset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  localparam int            SW      = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STV_LIM = SW'(STARVE_LIM);
  localparam logic [SW-1:0] STV_ONE = SW'(1);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    pick = m1_req;
    if (m0_req && m1_req) pick = (starve_q != STV_LIM);
  end

  // A loss is counted once per IDLE arbitration, not per stalled LOCK cycle.
  always_comb begin
    starve_d = starve_q;
    if (!m0_req) begin
      starve_d = '0;
    end else if (state_q == IDLE && sreq) begin
      if (!pick)                    starve_d = '0;
      else if (starve_q != STV_LIM) starve_d = starve_q + STV_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];
  assign pop   = s_data_ok & ~empty;
  assign push  = sreq & s_addr_ok;

  // A same-cycle pop frees the slot, so a full FIFO still admits a request then.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel     = gnt_q;
    sreq    = 1'b0;
    case (state_q)
      IDLE: begin
        sel  = pick;
        sreq = (m0_req | m1_req) & (~full | pop);
        if (sreq) begin
          gnt_d = pick;
          if (!s_addr_ok) state_d = LOCK;
        end
      end
      LOCK: begin
        sreq = 1'b1;
        if (s_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q | (s_data_ok & empty);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_q[wptr_q] <= sel;
  end

  assign s_req   = sreq;
  assign s_wr    = sel ? m1_wr    : m0_wr;
  assign s_size  = sel ? m1_size  : m0_size;
  assign s_wstrb = sel ? m1_wstrb : m0_wstrb;
  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_wdata = sel ? m1_wdata : m0_wdata;

  assign m0_addr_ok = s_addr_ok & sreq & ~sel;
  assign m1_addr_ok = s_addr_ok & sreq &  sel;
  assign m0_data_ok = pop & ~head;
  assign m1_data_ok = pop &  head;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  assign ot_cnt  = cnt_q;
  assign arb_err = err_q;

endmodule
`default_nettype wire
